// File: rtl/mac_pipe_pkg.sv
// Shared arithmetic helpers and type definitions for the neural-network datapath blocks.
package math_pack;

    typedef enum logic [0:0] {
        DSP    = 1'b0,
        FABRIC = 1'b1
    } multiply_t;

    // Working width for the helpers; callers sign-extend into it and truncate back out.
    localparam int MAX_WIDTH = 128;

    typedef logic signed [MAX_WIDTH-1:0] wide_t;

    // Clamp a signed value into the signed range of 'width' bits.
    function automatic wide_t sat_signed(input wide_t value, input int width);
        wide_t max_v;
        wide_t min_v;
        max_v = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        min_v = -max_v - wide_t'(1);
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

    // Drop 'frac' fraction bits, rounding half toward +inf.
    function automatic wide_t round_shift(input wide_t value, input int frac);
        if (frac <= 0) begin
            return value;
        end
        return (value + (wide_t'(1) <<< (frac - 1))) >>> frac;
    endfunction

endpackage

// File: rtl/mac_pipe_mult_pipe.sv
// Signed multiplier followed by a register chain carrying the beat's valid/first/last tags.
module mult_pipe
    import math_pack::*;
#(
    parameter multiply_t G_MODE        = DSP,
    parameter int        G_A_WIDTH     = 18,
    parameter int        G_B_WIDTH     = 18,
    parameter int        G_PIPE_STAGES = 2
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                en,
    input  logic                                in_valid,
    input  logic                                in_first,
    input  logic                                in_last,
    input  logic signed [G_A_WIDTH-1:0]         a,
    input  logic signed [G_B_WIDTH-1:0]         b,
    output logic                                out_valid,
    output logic                                out_first,
    output logic                                out_last,
    output logic signed [G_A_WIDTH+G_B_WIDTH-1:0] p
);

    localparam int P_WIDTH = G_A_WIDTH + G_B_WIDTH;
    localparam int STAGES  = (G_PIPE_STAGES < 1) ? 1 : G_PIPE_STAGES;

    logic signed [P_WIDTH-1:0] product;
    logic signed [P_WIDTH-1:0] prod_q [STAGES];
    logic [STAGES-1:0]         valid_q;
    logic [STAGES-1:0]         first_q;
    logic [STAGES-1:0]         last_q;

    generate
        if (G_PIPE_STAGES < 1) begin : g_bad_stages
            $error("mult_pipe: G_PIPE_STAGES must be at least 1");
        end
        if (G_MODE == DSP) begin : g_dsp
            assign product = a * b;
        end else begin : g_bad_mode
            $error("mult_pipe: only the DSP multiplier implementation is available");
            assign product = '0;
        end
    endgenerate

    // Shift the product and its tags down the chain whenever the pipeline is not stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            first_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else if (en) begin
            valid_q[0] <= in_valid;
            first_q[0] <= in_first;
            last_q[0]  <= in_last;
            prod_q[0]  <= product;
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                first_q[i] <= first_q[i-1];
                last_q[i]  <= last_q[i-1];
                prod_q[i]  <= prod_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_first = first_q[STAGES-1];
    assign out_last  = last_q[STAGES-1];
    assign p         = prod_q[STAGES-1];

endmodule

// File: rtl/mac_pipe.sv
// Pipelined signed multiply-accumulate: one rounded, saturated result per first..last frame.
module mac_pipe
    import math_pack::*;
#(
    parameter multiply_t G_MODE        = DSP,
    parameter int        G_A_WIDTH     = 18,
    parameter int        G_B_WIDTH     = 18,
    parameter int        G_ACC_WIDTH   = 48,
    parameter int        G_C_WIDTH     = 18,
    parameter int        G_FRAC_BITS   = 0,
    parameter int        G_PIPE_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_first,
    input  logic                          in_last,
    input  logic signed [G_A_WIDTH-1:0]   a,
    input  logic signed [G_B_WIDTH-1:0]   b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [G_C_WIDTH-1:0]   c,
    output logic                          c_sat
);

    localparam int P_WIDTH = G_A_WIDTH + G_B_WIDTH;

    generate
        if (G_ACC_WIDTH < P_WIDTH) begin : g_bad_acc
            $error("mac_pipe: G_ACC_WIDTH must hold the full product");
        end
        if (G_ACC_WIDTH > MAX_WIDTH - 2) begin : g_wide_acc
            $error("mac_pipe: G_ACC_WIDTH exceeds the math_pack working width");
        end
        if (G_FRAC_BITS < 0 || G_FRAC_BITS >= G_ACC_WIDTH) begin : g_bad_frac
            $error("mac_pipe: G_FRAC_BITS out of range");
        end
    endgenerate

    logic                      stall;
    logic                      en;
    logic                      prod_valid;
    logic                      prod_first;
    logic                      prod_last;
    logic signed [P_WIDTH-1:0] prod;

    logic signed [G_ACC_WIDTH-1:0] acc;
    logic                          acc_ovf;
    logic                          acc_valid;
    logic                          acc_last;

    logic signed [G_ACC_WIDTH:0]   acc_base;
    logic signed [G_ACC_WIDTH:0]   acc_sum;
    logic                          acc_sum_ovf;
    logic signed [G_ACC_WIDTH-1:0] acc_next;

    wide_t                         rounded;
    wide_t                         saturated;
    logic                          clipped;
    logic signed [G_C_WIDTH-1:0]   c_next;

    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = en;

    mult_pipe #(
        .G_MODE        (G_MODE),
        .G_A_WIDTH     (G_A_WIDTH),
        .G_B_WIDTH     (G_B_WIDTH),
        .G_PIPE_STAGES (G_PIPE_STAGES)
    ) u_mult_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_last   (in_last),
        .a         (a),
        .b         (b),
        .out_valid (prod_valid),
        .out_first (prod_first),
        .out_last  (prod_last),
        .p         (prod)
    );

    // Next accumulator value: one guard bit exposes signed overflow, which clamps to the rail.
    always_comb begin
        acc_base    = prod_first ? '0 : (G_ACC_WIDTH+1)'(acc);
        acc_sum     = acc_base + (G_ACC_WIDTH+1)'(prod);
        acc_sum_ovf = acc_sum[G_ACC_WIDTH] != acc_sum[G_ACC_WIDTH-1];
        acc_next    = acc_sum[G_ACC_WIDTH-1:0];
        if (acc_sum_ovf) begin
            acc_next = acc_sum[G_ACC_WIDTH] ? {1'b1, {(G_ACC_WIDTH-1){1'b0}}}
                                            : {1'b0, {(G_ACC_WIDTH-1){1'b1}}};
        end
    end

    // Accumulate stage; a first beat restarts the sum and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            acc_ovf   <= 1'b0;
            acc_valid <= 1'b0;
            acc_last  <= 1'b0;
        end else if (en) begin
            acc_valid <= prod_valid;
            acc_last  <= prod_last;
            if (prod_valid) begin
                acc     <= acc_next;
                acc_ovf <= prod_first ? acc_sum_ovf : (acc_ovf | acc_sum_ovf);
            end
        end
    end

    // Round away the fraction bits, then clip into the output range.
    always_comb begin
        rounded   = round_shift(wide_t'(acc), G_FRAC_BITS);
        saturated = sat_signed(rounded, G_C_WIDTH);
        clipped   = saturated != rounded;
        c_next    = G_C_WIDTH'(saturated);
    end

    // Output register: loads on a frame's last beat, otherwise retires the previous result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= '0;
            c_sat     <= 1'b0;
        end else if (en) begin
            out_valid <= acc_valid & acc_last;
            if (acc_valid & acc_last) begin
                c     <= c_next;
                c_sat <= clipped | acc_ovf;
            end
        end
    end

endmodule

// File: tb/tb_mac_pipe.sv
// Bench for mac_pipe: two instances (default, and 36-bit accumulator with 4 fraction bits)
// share one input stream; a frame-level model predicts every result.
module tb_mac_pipe;
    import math_pack::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic in_valid = 1'b0;
    logic in_first = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b1;
    logic signed [17:0] a = '0;
    logic signed [17:0] b = '0;

    logic in_ready0, in_ready1, out_valid0, out_valid1, c_sat0, c_sat1;
    logic signed [17:0] c0, c1;

    int  checks = 0;
    int  errors = 0;
    bit  rand_mode = 1'b0;

    typedef struct {
        longint c;
        bit     sat;
    } res_t;

    res_t   exp_q0[$];
    res_t   exp_q1[$];
    longint m_acc[2];
    bit     m_ovf[2];

    always #5 clk = ~clk;

    mac_pipe #(
        .G_MODE(DSP), .G_A_WIDTH(18), .G_B_WIDTH(18), .G_ACC_WIDTH(48),
        .G_C_WIDTH(18), .G_FRAC_BITS(0), .G_PIPE_STAGES(2)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_first(in_first), .in_last(in_last), .a(a), .b(b),
        .out_valid(out_valid0), .out_ready(out_ready), .c(c0), .c_sat(c_sat0)
    );

    mac_pipe #(
        .G_MODE(DSP), .G_A_WIDTH(18), .G_B_WIDTH(18), .G_ACC_WIDTH(36),
        .G_C_WIDTH(18), .G_FRAC_BITS(4), .G_PIPE_STAGES(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_first(in_first), .in_last(in_last), .a(a), .b(b),
        .out_valid(out_valid1), .out_ready(out_ready), .c(c1), .c_sat(c_sat1)
    );

    // Frame-level model: saturating running sum, floor((sum + half) / 2^F), clip to 18 bits.
    function automatic void model_beat(int k, longint pa, longint pb, bit first, bit last);
        int     fb;
        int     aw;
        longint lim;
        longint s;
        longint r;
        bit     o;
        res_t   e;
        fb  = (k == 0) ? 0 : 4;
        aw  = (k == 0) ? 48 : 36;
        lim = longint'(1) <<< (aw - 1);
        s   = (first ? 64'sd0 : m_acc[k]) + pa * pb;
        o   = 1'b0;
        if (s > lim - 1) begin
            s = lim - 1;
            o = 1'b1;
        end else if (s < -lim) begin
            s = -lim;
            o = 1'b1;
        end
        m_acc[k] = s;
        m_ovf[k] = first ? o : (m_ovf[k] | o);
        if (last) begin
            r = s;
            if (fb > 0) r = (s + (longint'(1) <<< (fb - 1))) >>> fb;
            e.sat = m_ovf[k];
            if (r > 131071) begin
                r = 131071;
                e.sat = 1'b1;
            end else if (r < -131072) begin
                r = -131072;
                e.sat = 1'b1;
            end
            e.c = r;
            if (k == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
        end
    endfunction

    task automatic check_val(string name, logic signed [63:0] actual, logic signed [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_out(int k, logic signed [17:0] cv, logic sv);
        res_t e;
        bit   empty;
        empty = (k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0);
        checks++;
        if (empty) begin
            errors++;
            $display("[TB] FAIL dut%0d unexpected result: got c=%0d sat=%0d, expected no result", k, cv, sv);
        end else begin
            if (k == 0) e = exp_q0.pop_front();
            else        e = exp_q1.pop_front();
            if (longint'(cv) !== e.c || sv !== e.sat) begin
                errors++;
                $display("[TB] FAIL dut%0d result: got c=%0d sat=%0d, expected c=%0d sat=%0d",
                         k, cv, sv, e.c, e.sat);
            end
        end
    endtask

    // Compare process: on every output transfer check both DUTs, then feed accepted beats to the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q0.delete();
            exp_q1.delete();
            m_acc = '{0, 0};
            m_ovf = '{0, 0};
        end else begin
            if (out_valid0 === 1'b1 && out_ready) check_out(0, c0, c_sat0);
            if (out_valid1 === 1'b1 && out_ready) check_out(1, c1, c_sat1);
            if (in_valid && in_ready0 === 1'b1) begin
                model_beat(0, longint'(a), longint'(b), in_first, in_last);
                model_beat(1, longint'(a), longint'(b), in_first, in_last);
            end
        end
    end

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (rand_mode) out_ready = ($urandom_range(0, 9) < 7);
        end
    endtask

    task automatic applyStimulus(logic signed [17:0] va, logic signed [17:0] vb, bit f, bit l);
        int n;
        bit took;
        n = 0;
        took = 1'b0;
        a = va; b = vb; in_first = f; in_last = l; in_valid = 1'b1;
        while (!took && n < 200) begin
            @(negedge clk);
            took = (in_ready0 === 1'b1);
            @(posedge clk); #1;
            n++;
            if (rand_mode) out_ready = ($urandom_range(0, 9) < 7);
        end
        in_valid = 1'b0;
        if (!took) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept timeout: got in_ready=0 for 200 cycles, expected 1");
        end
    endtask

    // Waits for a result; exp_lat counts clock edges after the acceptance edge (3 => 4 cycles of latency).
    task automatic checkOutput(string name, longint e0, bit s0, longint e1, bit s1, int exp_lat);
        int n;
        n = 0;
        while (out_valid0 !== 1'b1 && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_valid0 !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got out_valid=0, expected 1", name);
        end else begin
            if (exp_lat >= 0) check_val({name, " latency"}, n, exp_lat);
            check_val({name, " c0"}, c0, e0);
            check_val({name, " sat0"}, c_sat0, s0);
            check_val({name, " c1"}, c1, e1);
            check_val({name, " sat1"}, c_sat1, s1);
        end
    endtask

    initial begin
        int len;
        int v;
        logic signed [17:0] ra, rb;

        #1;
        check_val("reset out_valid0", out_valid0, 0);
        check_val("reset c0", c0, 0);
        check_val("reset c_sat0", c_sat0, 0);
        check_val("reset in_ready0", in_ready0, 1);
        check_val("reset out_valid1", out_valid1, 0);
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Single beat, also pins the latency.
        applyStimulus(3, -4, 1, 1);
        checkOutput("single", -12, 0, -1, 0, 3);
        idle(3);

        // Three-beat frame followed immediately by a one-beat frame.
        applyStimulus(2, 5, 1, 0);
        applyStimulus(-3, 7, 0, 0);
        applyStimulus(4, 4, 0, 1);
        applyStimulus(3, 3, 1, 1);
        checkOutput("frame3", 5, 0, 0, 0, -1);
        @(posedge clk); #1;
        check_val("no bubble valid", out_valid0, 1);
        check_val("no bubble c0", c0, 9);
        idle(4);

        // Rounding (dut1 has 4 fraction bits) and output saturation.
        applyStimulus(1, 24, 1, 1);    checkOutput("round 1x24", 24, 0, 2, 0, -1);    idle(2);
        applyStimulus(-1, 24, 1, 1);   checkOutput("round -1x24", -24, 0, -1, 0, -1); idle(2);
        applyStimulus(1, 8, 1, 1);     checkOutput("round 1x8", 8, 0, 1, 0, -1);      idle(2);
        applyStimulus(1, 7, 1, 1);     checkOutput("round 1x7", 7, 0, 0, 0, -1);      idle(2);
        applyStimulus(1000, 1000, 1, 1);
        checkOutput("sat pos", 131071, 1, 62500, 0, -1);
        idle(2);
        applyStimulus(-1000, 1000, 1, 1);
        checkOutput("sat neg", -131072, 1, -62500, 0, -1);
        idle(2);

        // Accumulator overflow on the 36-bit instance, repeated over two frames.
        for (int f = 0; f < 2; f++) begin
            applyStimulus(-131072, -131072, 1, 0);
            applyStimulus(-131072, -131072, 0, 0);
            applyStimulus(-131072, -131072, 0, 1);
            checkOutput("acc overflow", 131071, 1, 131071, 1, -1);
            idle(2);
        end

        // Back-pressure: four results queue up, the fifth beat must wait.
        out_ready = 1'b0;
        applyStimulus(1, 1, 1, 1);
        applyStimulus(2, 2, 1, 1);
        applyStimulus(3, 3, 1, 1);
        applyStimulus(4, 4, 1, 1);
        a = 5; b = 5; in_first = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("stall in_ready", in_ready0, 0);
            check_val("stall c0", c0, 1);
            check_val("stall c1", c1, 0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        applyStimulus(5, 5, 1, 1);
        idle(10);

        // Reset in the middle of a frame while a result is held.
        out_ready = 1'b0;
        applyStimulus(5, 5, 1, 1);
        applyStimulus(1, 1, 1, 0);
        applyStimulus(1, 1, 0, 0);
        checkOutput("held before reset", 25, 0, 2, 0, -1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async reset out_valid0", out_valid0, 0);
        check_val("async reset c0", c0, 0);
        check_val("async reset c_sat0", c_sat0, 0);
        check_val("async reset in_ready0", in_ready0, 1);
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(2, 2, 0, 1);
        checkOutput("after reset", 4, 0, 0, 0, 3);
        idle(3);

        // Random frames with gaps, random out_ready and occasional restarts.
        rand_mode = 1'b1;
        for (int f = 0; f < 150; f++) begin
            len = $urandom_range(1, 4);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) idle(1);
                if (f % 2 == 0) begin
                    ra = 18'($urandom);
                    rb = 18'($urandom);
                end else begin
                    v = $urandom_range(0, 200) - 100; ra = 18'(v);
                    v = $urandom_range(0, 200) - 100; rb = 18'(v);
                end
                applyStimulus(ra, rb, (i == 0) || ($urandom_range(0, 19) == 0), i == len - 1);
            end
        end
        rand_mode = 1'b0;
        out_ready = 1'b1;
        idle(15);
        check_val("drain dut0", exp_q0.size(), 0);
        check_val("drain dut1", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
